// File: rtl/pkg_hydra.sv
// Shared page-memory constants for the packet SRAM free-page path.
package pkg_hydra;
    localparam int PAGE_AW   = 11;
    localparam int NUM_PAGES = 2048;
    localparam int CNT_W     = 12;

    typedef logic [PAGE_AW-1:0] page_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a registered pointer,
// pointer moves past the winner when the grant is taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (advance && found)
            ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end
endmodule

// File: rtl/page_alloc_arbiter.sv
// Free-page list sequencer: arbitrates page allocations and releases,
// strobes the free-list FIFO and tracks the free-page count.
module page_alloc_arbiter
    import pkg_hydra::*;
#(
    parameter int N_WR   = 16,
    parameter int N_RD   = 4,
    parameter int LOW_WM = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_WR-1:0]         alloc_req,
    output logic [N_WR-1:0]         alloc_gnt,
    output logic [PAGE_AW-1:0]      alloc_page,
    input  logic [N_RD-1:0]         rel_valid,
    input  logic [N_RD*PAGE_AW-1:0] rel_page,
    output logic [N_RD-1:0]         rel_ready,
    output logic                    fl_pop_head,
    input  logic [PAGE_AW-1:0]      fl_head_addr,
    output logic                    fl_push_tail,
    output logic [PAGE_AW-1:0]      fl_tail_addr,
    output logic [CNT_W-1:0]        free_cnt,
    output logic                    low_water,
    output logic                    err_double_rel
);
    logic             full;
    logic             push_d1;
    logic             alloc_ok;
    logic             rel_ok;
    logic [N_WR-1:0]  alloc_req_m;
    logic [N_RD-1:0]  rel_valid_m;
    logic [CNT_W-1:0] cnt_nxt;

    assign full = (free_cnt == CNT_W'(NUM_PAGES));

    // A page pushed last cycle is not yet visible at the free list's registered
    // head; if it is the only free page, allocation must wait one more cycle.
    assign alloc_ok = !rst && (free_cnt > CNT_W'(push_d1));
    assign rel_ok   = !rst && !full;

    assign alloc_req_m = alloc_ok ? alloc_req : '0;
    assign rel_valid_m = rel_ok ? rel_valid : '0;

    rr_arbiter #(.N(N_WR)) u_alloc_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (alloc_req_m),
        .advance (fl_pop_head),
        .gnt     (alloc_gnt)
    );

    rr_arbiter #(.N(N_RD)) u_rel_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (rel_valid_m),
        .advance (fl_push_tail),
        .gnt     (rel_ready)
    );

    assign fl_pop_head  = |alloc_gnt;
    assign fl_push_tail = |rel_ready;
    assign alloc_page   = fl_head_addr;

    always_comb begin
        fl_tail_addr = '0;
        for (int j = 0; j < N_RD; j++)
            if (rel_ready[j])
                fl_tail_addr = rel_page[j*PAGE_AW +: PAGE_AW];
    end

    always_comb begin
        cnt_nxt = free_cnt;
        if (fl_pop_head && !fl_push_tail)
            cnt_nxt = free_cnt - CNT_W'(1);
        else if (fl_push_tail && !fl_pop_head)
            cnt_nxt = free_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt       <= CNT_W'(NUM_PAGES);
            low_water      <= 1'b0;
            push_d1        <= 1'b0;
            err_double_rel <= 1'b0;
        end else begin
            free_cnt  <= cnt_nxt;
            low_water <= (cnt_nxt < CNT_W'(LOW_WM));
            push_d1   <= fl_push_tail;
            if (full && (|rel_valid))
                err_double_rel <= 1'b1;
        end
    end
endmodule

// File: tb/tb_page_alloc_arbiter.sv
// Scoreboard bench: a free-list queue model predicts every cycle's outputs.
module tb_page_alloc_arbiter;
    localparam int N_WR   = 16;
    localparam int N_RD   = 4;
    localparam int LOW_WM = 64;
    localparam int NPG    = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_WR-1:0]   alloc_req = '0;
    logic [N_WR-1:0]   alloc_gnt;
    logic [10:0]       alloc_page;
    logic [N_RD-1:0]   rel_valid = '0;
    logic [N_RD*11-1:0] rel_page = '0;
    logic [N_RD-1:0]   rel_ready;
    logic              fl_pop_head;
    logic [10:0]       fl_head_addr = '0;
    logic              fl_push_tail;
    logic [10:0]       fl_tail_addr;
    logic [11:0]       free_cnt;
    logic              low_water;
    logic              err_double_rel;

    page_alloc_arbiter #(.N_WR(N_WR), .N_RD(N_RD), .LOW_WM(LOW_WM)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_page(alloc_page),
        .rel_valid(rel_valid), .rel_page(rel_page), .rel_ready(rel_ready),
        .fl_pop_head(fl_pop_head), .fl_head_addr(fl_head_addr),
        .fl_push_tail(fl_push_tail), .fl_tail_addr(fl_tail_addr),
        .free_cnt(free_cnt), .low_water(low_water), .err_double_rel(err_double_rel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_WR-1:0] gnt;
        logic [10:0]     page;
        logic [N_RD-1:0] rdy;
        logic [10:0]     tail;
        int              cnt;
        logic            low;
        logic            err;
        int              cyc;
    } exp_t;

    typedef struct {
        logic [10:0] page;
        int          rdy_cyc;   // first cycle this page may be handed out
    } fl_t;

    exp_t sb[$];
    fl_t  fl_q[$];
    int   m_aptr, m_rptr, cyc;
    logic m_err;
    int   n_chk = 0, n_pass = 0;

    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++)
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        return -1;
    endfunction

    task automatic model_reset();
        fl_t f;
        fl_q.delete();
        for (int i = 0; i < NPG; i++) begin
            f.page = 11'(i);
            f.rdy_cyc = 0;
            fl_q.push_back(f);
        end
        m_aptr = 0;
        m_rptr = 0;
        m_err  = 1'b0;
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
    endtask

    // One clock cycle: drive inputs, predict the outputs, advance the model.
    task automatic step(input logic r, input logic [N_WR-1:0] areq,
                        input logic [N_RD-1:0] rv, input logic [N_RD*11-1:0] rp);
        exp_t e;
        fl_t  f;
        int   aw, rw;
        logic err_set;
        @(posedge clk);
        #1;
        rst = r; alloc_req = areq; rel_valid = rv; rel_page = rp;
        if (r) model_reset();
        fl_head_addr = (fl_q.size() != 0) ? fl_q[0].page : 11'h0;
        e.gnt = '0; e.page = '0; e.rdy = '0; e.tail = '0;
        e.cnt = fl_q.size(); e.low = (fl_q.size() < LOW_WM); e.err = m_err; e.cyc = cyc;
        aw = -1; rw = -1; err_set = 1'b0;
        if (!r) begin
            if (fl_q.size() != 0 && fl_q[0].rdy_cyc <= cyc)
                aw = rr_pick(32'(areq), m_aptr, N_WR);
            if (rv != 0) begin
                if (fl_q.size() == NPG) err_set = 1'b1;
                else rw = rr_pick(32'(rv), m_rptr, N_RD);
            end
        end
        if (aw >= 0) begin e.gnt[aw] = 1'b1; e.page = fl_q[0].page; end
        if (rw >= 0) begin e.rdy[rw] = 1'b1; e.tail = rp[rw*11 +: 11]; end
        sb.push_back(e);
        if (aw >= 0) begin void'(fl_q.pop_front()); m_aptr = (aw + 1) % N_WR; end
        if (rw >= 0) begin
            f.page = e.tail; f.rdy_cyc = cyc + 2;
            fl_q.push_back(f);
            m_rptr = (rw + 1) % N_RD;
        end
        if (err_set) m_err = 1'b1;
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("alloc_gnt",   e.cyc, 32'(alloc_gnt),    32'(e.gnt));
                chk("fl_pop_head", e.cyc, 32'(fl_pop_head),  32'(e.gnt != 0));
                if (e.gnt != 0) chk("alloc_page", e.cyc, 32'(alloc_page), 32'(e.page));
                chk("rel_ready",   e.cyc, 32'(rel_ready),    32'(e.rdy));
                chk("fl_push_tail",e.cyc, 32'(fl_push_tail), 32'(e.rdy != 0));
                if (e.rdy != 0) chk("fl_tail_addr", e.cyc, 32'(fl_tail_addr), 32'(e.tail));
                chk("free_cnt",    e.cyc, 32'(free_cnt),     32'(e.cnt));
                chk("low_water",   e.cyc, 32'(low_water),    32'(e.low));
                chk("err_double_rel", e.cyc, 32'(err_double_rel), 32'(e.err));
            end
        end
    end

    initial begin : stim
        logic [N_RD*11-1:0] rp;
        cyc = 0;
        model_reset();
        repeat (2) step(1'b1, '0, '0, '0);

        // release while full: refused, sticky error
        repeat (3) step(1'b0, '0, 4'b1000, 44'({$urandom(), $urandom()}));
        // two requesters alternate
        repeat (4) step(1'b0, 16'h0005, '0, '0);
        // drain to empty, then requests must stall
        while (fl_q.size() > 0) step(1'b0, 16'hFFFF, '0, '0);
        repeat (3) step(1'b0, 16'hFFFF, '0, '0);

        // single release into empty list; requester waits two cycles for it
        rp = '0;
        rp[21:11] = 11'h3A5;
        step(1'b0, 16'h0001, 4'b0010, rp);
        repeat (3) step(1'b0, 16'h0001, '0, '0);

        // refill to 500 then hold steady with concurrent alloc+release
        while (fl_q.size() < 500)
            step(1'b0, '0, 4'($urandom_range(1, 15)), 44'({$urandom(), $urandom()}));
        repeat (100)
            step(1'b0, 16'($urandom_range(1, 65535)), 4'($urandom_range(1, 15)),
                 44'({$urandom(), $urandom()}));
        // free-running random mix
        repeat (300)
            step(1'b0, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom()),
                 4'($urandom_range(0, 15)), 44'({$urandom(), $urandom()}));

        // reset, drain to 1000, then reset mid-drain
        repeat (2) step(1'b1, '0, '0, '0);
        while (fl_q.size() > 1000) step(1'b0, 16'hFFFF, '0, '0);
        repeat (2) step(1'b1, 16'hFFFF, 4'hF, '0);
        repeat (6) step(1'b0, 16'hFFFF, '0, '0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/page_alloc_arbiter.md
Name: page_alloc_arbiter

Overview:
- Sequences the shared free-page list of the packet SRAM.
- Up to N_WR ingress write engines request one 11-bit page per grant. Up to N_RD egress read engines return pages after readout.
- Round-robin arbitrates each side independently, drives the free list's pop/push strobes and maintains the free-page count and back-pressure flags.
- Sits between the write/read engines and the free-page FIFO instance.

Parameters:
N_WR, 16, number of page-allocation requesters
N_RD, 4, number of page-release requesters
LOW_WM, 64, free_cnt below this asserts low_water

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
alloc_req  in  N_WR  per-engine level request; held until granted
alloc_gnt  out  N_WR  one-hot grant pulse, at most one bit per cycle
alloc_page  out  11  page address; valid in the cycle alloc_gnt is nonzero
rel_valid  in  N_RD  per-engine release request
rel_page  in  N_RD*11  release page per engine, slice j = bits [11j+10:11j]
rel_ready  out  N_RD  one-hot accept pulse; page consumed when rel_valid&rel_ready
fl_pop_head  out  1  to free list: consume current head
fl_head_addr  in  11  from free list: current head page (registered there)
fl_push_tail  out  1  to free list: append page
fl_tail_addr  out  11  to free list: page to append
free_cnt  out  12  free pages, 0..2048
low_water  out  1  free_cnt < LOW_WM
err_double_rel  out  1  sticky: release attempted while free_cnt == 2048

Behaviour:
- Reset (async assert, sync-safe deassert):
  - free_cnt = 2048; both RR pointers = 0; err_double_rel = 0.
  - All grants, ready, fl_pop_head and fl_push_tail = 0.
- Alloc side (combinational grant from registered state):
  - If free_cnt != 0 and alloc_req != 0, grant the first requester at or after alloc_ptr, cyclically.
  - alloc_gnt[i] = 1 and fl_pop_head = 1 in the same cycle; alloc_page = fl_head_addr in that cycle.
  - Next cycle alloc_ptr = i+1 mod N_WR.
- free_cnt == 0: no grant, alloc_ptr holds, requests stay pending.
- One alloc per cycle max; a requester holding alloc_req is granted again only after every other active requester has been served.
- Release side, same RR scheme on rel_valid with rel_ptr:
  - Winner j gets rel_ready[j] = 1, fl_push_tail = 1, fl_tail_addr = rel_page slice j. Same cycle, no extra latency.
  - Next cycle rel_ptr = j+1 mod N_RD.
- free_cnt == 2048 and any rel_valid: no ready, no push, err_double_rel set (sticky until rst).
- free_cnt update, registered:
  - alloc only: -1.
  - release only: +1.
  - both in the same cycle: unchanged.
  - A page released in cycle t is not allocatable before cycle t+2, because the free list's registered head isolates it; no bypass.
- low_water is registered from the next-state free_cnt, so it is coincident with free_cnt.
- Reset mid-operation:
  - Any granted page in that cycle is lost from the controller's view; the free list is reset by the same domain.
  - Pending requests must be re-issued by the engines after reset.
- Width rules: free_cnt is 12-bit unsigned. The ±1 arithmetic never wraps by construction, due to the empty/full gating above.

Decomposition:
- Shared package (pkg_hydra):
  - PAGE_AW = 11
  - NUM_PAGES = 2048
  - CNT_W = 12
  - typedef page_t = logic [PAGE_AW-1:0]
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, advance.
  - Outputs: one-hot gnt.
  - Internal: pointer update on advance.
  - Instantiated twice (alloc N_WR, release N_RD).

Test Plan:
- After reset, alloc_req = 16'h0005 held for 4 cycles -> grants alternate bit0, bit2, bit0, bit2; alloc_page = free-list head each cycle; free_cnt 2048→2044.
- Drain all 2048 pages with alloc_req = 16'hFFFF -> free_cnt = 0, low_water = 1 from free_cnt = 63. Further requests get no gnt and no fl_pop_head.
- At free_cnt = 0, rel_valid = 4'b0010, page 11'h3A5 -> rel_ready[1], fl_tail_addr = 11'h3A5, free_cnt = 1. A waiting requester is granted no earlier than 2 cycles later and receives 11'h3A5.
- Simultaneous alloc and release every cycle for 100 cycles at free_cnt = 500 -> free_cnt stays 500; each rel_ready and alloc_gnt is one-hot per cycle.
- At free_cnt = 2048, rel_valid = 4'b1000 -> rel_ready = 0, fl_push_tail = 0, err_double_rel = 1, held until rst.
- Assert rst mid-drain at free_cnt = 1000 -> outputs clear immediately (async); after release, free_cnt = 2048 and RR pointers restart at requester 0.
